stage_ex_muldiv: RTL

//  Execute stage directly upstream of the memory stage; its EX/MEM latch outputs drive the memory stage's inputs.
//  - ALU operations complete in a single cycle.
//  - MULT/MULTU/DIV/DIVU run on an iterative 32-step unit writing HI/LO; outStall freezes IF/ID/EX during the run.
//  - Forwards store data, rt/rd index and all MEM/WB control to the memory stage.

---
 rtl/stage_ex_muldiv.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/stage_ex_muldiv.sv
// Execute stage with single-cycle ALU, iterative 32-step mul/div unit (HI/LO) and EX/MEM latch; 1-cycle latch latency.
// outStall holds upstream during a mul/div run; EX_FAST_MUL_EN selects a combinational multiplier for MULT/MULTU.
module stage_ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             enable,
  input  logic [WIDTH-1:0] inOperandA,
  input  logic [WIDTH-1:0] inOperandB,
  input  logic [WIDTH-1:0] inStoreData,
  input  logic [4:0]       inShamt,
  input  logic [3:0]       inAluOp,
  input  logic [2:0]       inMdOp,
  input  logic             inMemWrite,
  input  logic             inMemRead,
  input  logic             inRegWrite,
  input  logic [1:0]       inMemtoReg,
  input  logic [1:0]       inFlagStore,
  input  logic [2:0]       inFlagLoad,
  input  logic [4:0]       inMuxRtRd,
  input  logic [4:0]       inRegRt,
  output logic             outStall,
  output logic [WIDTH-1:0] outAluResult,
  output logic [WIDTH-1:0] outStoreData,
  output logic             outMemWrite,
  output logic             outMemRead,
  output logic             outRegWrite,
  output logic [1:0]       outMemtoReg,
  output logic [1:0]       outFlagStore,
  output logic [2:0]       outFlagLoad,
  output logic [4:0]       outMuxRtRd,
  output logic [4:0]       outRegRt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  md_state_t state, state_nxt;

  logic [5:0]         count;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   raw_a;
  logic [2*WIDTH-1:0] work;
  logic               is_div, is_signed, sign_a, sign_b;

  logic               md_valid, op_div, op_sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   alu_res;

  assign md_valid = (inMdOp >= 3'd1) && (inMdOp <= 3'd4);
  assign op_div   = (inMdOp == 3'd3) || (inMdOp == 3'd4);
  assign op_sgn   = (inMdOp == 3'd1) || (inMdOp == 3'd3);
  assign mag_a    = (op_sgn && inOperandA[WIDTH-1]) ? -inOperandA : inOperandA;
  assign mag_b    = (op_sgn && inOperandB[WIDTH-1]) ? -inOperandB : inOperandB;

`ifdef EX_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = op_sgn ? {{WIDTH{inOperandA[WIDTH-1]}}, inOperandA} : {{WIDTH{1'b0}}, inOperandA};
  assign ext_b     = op_sgn ? {{WIDTH{inOperandB[WIDTH-1]}}, inOperandB} : {{WIDTH{1'b0}}, inOperandB};
  assign fast_prod = ext_a * ext_b;
`endif

  // Multiply: work = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, work[WIDTH-1:1]};

  // Divide: work = {remainder, dividend/quotient}, shifted left each step.
  assign div_shift = work[2*WIDTH-1:WIDTH-1];
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};
  assign div_next  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  work[WIDTH-2:0], 1'b1};

  assign prod_fix = (is_signed && (sign_a ^ sign_b)) ? -work : work;
  assign quo_fix  = (is_signed && (sign_a ^ sign_b)) ? -work[WIDTH-1:0] : work[WIDTH-1:0];
  assign rem_fix  = (is_signed && sign_a) ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    outStall  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && md_valid) begin
          outStall  = 1'b1;
          state_nxt = BUSY;
`ifdef EX_FAST_MUL_EN
          if (!op_div) state_nxt = DONE;
`endif
        end
      end
      BUSY: begin
        outStall = 1'b1;
        if (count == LAST_STEP) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!rstN) outStall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      count     <= '0;
      work      <= '0;
      opnd      <= '0;
      raw_a     <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && md_valid) begin
            count     <= '0;
            is_div    <= op_div;
            is_signed <= op_sgn;
            sign_a    <= op_sgn & inOperandA[WIDTH-1];
            sign_b    <= op_sgn & inOperandB[WIDTH-1];
            raw_a     <= inOperandA;
            opnd      <= op_div ? mag_b : mag_a;
            work      <= op_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
`ifdef EX_FAST_MUL_EN
            // Product is already signed-correct, so suppress the DONE sign fix.
            if (!op_div) begin
              work      <= fast_prod;
              is_signed <= 1'b0;
            end
`endif
          end
        end
        BUSY: begin
          count <= count + 6'd1;
          work  <= is_div ? div_next : mul_next;
        end
        DONE: begin
          if (is_div) begin
            if (opnd == '0) begin
              hi <= raw_a;
              lo <= {WIDTH{1'b1}};
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    case (inAluOp)
      4'd0:  alu_res = inOperandA + inOperandB;
      4'd1:  alu_res = inOperandA - inOperandB;
      4'd2:  alu_res = inOperandA & inOperandB;
      4'd3:  alu_res = inOperandA | inOperandB;
      4'd4:  alu_res = inOperandA ^ inOperandB;
      4'd5:  alu_res = ~(inOperandA | inOperandB);
      4'd6:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(inOperandA) < $signed(inOperandB))};
      4'd7:  alu_res = {{(WIDTH-1){1'b0}}, (inOperandA < inOperandB)};
      4'd8:  alu_res = inOperandB << inShamt;
      4'd9:  alu_res = inOperandB >> inShamt;
      4'd10: alu_res = $unsigned($signed(inOperandB) >>> inShamt);
      4'd11: alu_res = {inOperandB[15:0], 16'h0000};
      4'd12: alu_res = hi;
      4'd13: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      outAluResult <= '0;
      outStoreData <= '0;
      outMemWrite  <= 1'b0;
      outMemRead   <= 1'b0;
      outRegWrite  <= 1'b0;
      outMemtoReg  <= '0;
      outFlagStore <= '0;
      outFlagLoad  <= '0;
      outMuxRtRd   <= '0;
      outRegRt     <= '0;
    end else if (enable) begin
      if (outStall) begin
        outMemWrite <= 1'b0;
        outMemRead  <= 1'b0;
        outRegWrite <= 1'b0;
      end else begin
        outAluResult <= alu_res;
        outStoreData <= inStoreData;
        outMemWrite  <= inMemWrite;
        outMemRead   <= inMemRead;
        outRegWrite  <= inRegWrite;
        outMemtoReg  <= inMemtoReg;
        outFlagStore <= inFlagStore;
        outFlagLoad  <= inFlagLoad;
        outMuxRtRd   <= inMuxRtRd;
        outRegRt     <= inRegRt;
      end
    end
  end

endmodule
